// File: rtl/count_frame_receiver_pkg.sv
// Shared definitions for the count-frame receiver: deserializer FSM states,
// channel ordering of a batch and the default batch size.
package count_frame_receiver_pkg;

    // Bit-level deserializer states
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_e;

    // Byte position of each coincidence count inside a batch
    localparam int unsigned CH_A    = 0;
    localparam int unsigned CH_B    = 1;
    localparam int unsigned CH_BP   = 2;
    localparam int unsigned CH_AP   = 3;
    localparam int unsigned CH_AB   = 4;
    localparam int unsigned CH_ABP  = 5;
    localparam int unsigned CH_APB  = 6;
    localparam int unsigned CH_APBP = 7;
    localparam int unsigned CH_ABBP = 8;

    localparam int unsigned NUM_CHAN_DEFAULT = 9;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial deserializer with a 2-flop input synchronizer.
// Optional build macro RX_MAJORITY_VOTE_EN: each start/data/stop sample is the
// majority of three consecutive samples centred on mid-bit. The decision is
// always taken one cycle after mid-bit so output timing is the same either way.
module uart_rx_core
    import count_frame_receiver_pkg::*;
#(
    parameter int unsigned ClksPerBit = 25
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o,
    output logic       idle_high_o
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2);
    localparam logic [CntW-1:0] BitEnd  = CntW'(ClksPerBit - 1);

`ifdef RX_MAJORITY_VOTE_EN
    localparam int unsigned HistW = 3;
`else
    localparam int unsigned HistW = 2;
`endif

    logic [1:0]       sync_q;
    logic [HistW-1:0] hist_q;   // [0] newest synchronized sample
    logic             sample;
    logic             fall;

    rx_state_e        state_q;
    logic [CntW-1:0]  cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;

    // Synchronize the raw line and keep a short history for edge/vote logic
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            hist_q <= '1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            hist_q <= {hist_q[HistW-2:0], sync_q[1]};
        end
    end

    // hist_q[1] is the mid-bit sample whenever a decision is taken
`ifdef RX_MAJORITY_VOTE_EN
    assign sample = (hist_q[2] & hist_q[1]) | (hist_q[1] & hist_q[0]) |
                    (hist_q[2] & hist_q[0]);
`else
    assign sample = hist_q[1];
`endif

    assign fall = hist_q[1] & ~hist_q[0];

    // Receive FSM with registered byte/valid/error outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fall) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfCnt) begin
                        cnt_q   <= '0;
                        state_q <= sample ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == BitEnd) begin
                        cnt_q   <= '0;
                        shift_q <= {sample, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == BitEnd) begin
                        cnt_q <= '0;
                        if (sample) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= StWaitHigh;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (hist_q[0]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != StIdle);
    assign idle_high_o = (state_q == StIdle) && hist_q[0];

endmodule

// File: rtl/count_frame_receiver.sv
// Receives batches of NUM_CHAN count bytes over a serial line and publishes
// each complete batch atomically on counts_flat. A long idle line or a framing
// error restarts batch alignment at channel 0.
// Optional build macro RX_MAJORITY_VOTE_EN (see uart_rx_core).
module count_frame_receiver
    import count_frame_receiver_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 100_000_000,
    parameter int unsigned BAUD_RATE        = 4_000_000,
    parameter int unsigned NUM_CHAN         = NUM_CHAN_DEFAULT,
    parameter int unsigned IDLE_RESYNC_BITS = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx,
    output logic [7:0]              rx_data,
    output logic                    rx_valid,
    output logic [3:0]              rx_chan,
    output logic                    batch_valid,
    output logic [8*NUM_CHAN-1:0]   counts_flat,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
    localparam int unsigned IDLE_LIMIT   = IDLE_RESYNC_BITS * CLKS_PER_BIT;
    localparam int unsigned IdleW        = $clog2(IDLE_LIMIT);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_LIMIT - 1);
    localparam logic [3:0] LastChan       = 4'(NUM_CHAN - 1);

    logic [7:0] core_data;
    logic       core_valid;
    logic       core_ferr;
    logic       core_idle_high;

    logic [3:0]                chan_q;
    logic [NUM_CHAN-1:0][7:0]  shadow_q;
    logic [8*NUM_CHAN-1:0]     counts_q;
    logic [7:0]                rx_data_q;
    logic [3:0]                rx_chan_q;
    logic                      rx_valid_q;
    logic                      batch_valid_q;
    logic                      frame_err_q;
    logic [IdleW-1:0]          idle_cnt_q;
    logic                      resync;

    uart_rx_core #(
        .ClksPerBit (CLKS_PER_BIT)
    ) u_core (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .data_o      (core_data),
        .valid_o     (core_valid),
        .frame_err_o (core_ferr),
        .busy_o      (busy),
        .idle_high_o (core_idle_high)
    );

    // Count consecutive idle-high cycles, saturating at the resync threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else if (!core_idle_high) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != IdleLast) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    assign resync = core_idle_high && (idle_cnt_q == IdleLast) && (chan_q != 4'd0);

    // Channel indexing, shadow capture and atomic batch publication.
    // Resetting the index discards the shadow: stale entries are overwritten
    // before the next batch can complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q        <= '0;
            shadow_q      <= '0;
            counts_q      <= '0;
            rx_data_q     <= '0;
            rx_chan_q     <= '0;
            rx_valid_q    <= 1'b0;
            batch_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            batch_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            if (core_valid) begin
                rx_data_q        <= core_data;
                rx_chan_q        <= chan_q;
                rx_valid_q       <= 1'b1;
                shadow_q[chan_q] <= core_data;
                if (chan_q == LastChan) begin
                    for (int k = 0; k < int'(NUM_CHAN); k++) begin
                        counts_q[8*k +: 8] <= (k == int'(NUM_CHAN) - 1) ? core_data
                                                                        : shadow_q[k];
                    end
                    batch_valid_q <= 1'b1;
                    chan_q        <= '0;
                end else begin
                    chan_q <= chan_q + 4'd1;
                end
            end else if (core_ferr) begin
                frame_err_q <= 1'b1;
                chan_q      <= '0;
            end else if (resync) begin
                chan_q <= '0;
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_chan     = rx_chan_q;
    assign batch_valid = batch_valid_q;
    assign counts_flat = counts_q;
    assign frame_err   = frame_err_q;

endmodule
